// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder backing-store responder.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mem_responder_pkg;

  // Transaction FSM: IDLE accepts a request, WAIT counts down the latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  // Number of byte-offset bits in a word address: log2(data_width/8).
  function automatic int byte_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_responder_store.sv
// DEPTH x DATA_WIDTH word array; synchronous write port, asynchronous read port.
// Latency: write commits at the clock edge, read data is combinational from raddr_i.
// Backpressure: none; one write and one read may occur every cycle.
module mem_responder_store #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  // Contents are deliberately not reset so the array maps onto plain RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Single write port, enabled only on the committing cycle of a write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder for a single-word rd/wr pulse handshake.
// Latency: mem_ready pulses LATENCY cycles after the request edge (one cycle wide).
// Backpressure: none; requests arriving while busy are dropped, initiator waits for mem_ready.
// Optional MEM_RESPONDER_RANGE_ERR_EN: adds mem_err and suppresses out-of-range accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  ,
  output logic                  mem_err
`endif
);

  localparam int BB = byte_bits(DATA_WIDTH);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_t           state_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] widx;
  logic [SW-1:0]         slot;
  logic                  range_err;
  logic                  commit;
  logic                  store_we_d;
  logic [DATA_WIDTH-1:0] store_rdata;
  logic [DATA_WIDTH-1:0] resp_data_d;

  // Word index drops the byte offset; the slot is its low log2(DEPTH) bits.
  assign widx = addr_q >> BB;
  assign slot = widx[SW-1:0];

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  assign range_err = (widx >= ADDR_WIDTH'(DEPTH));
  assign mem_err   = err_q;
`else
  // Without range checking the upper index bits simply wrap away.
  logic unused_widx_hi;
  assign range_err      = 1'b0;
  assign unused_widx_hi = ^{widx[ADDR_WIDTH-1:SW], err_q};
`endif

  // Final countdown cycle of a transaction; reset at the same edge cancels it.
  assign commit     = (state_q == WAIT) && (cnt_q == '0) && !rst;
  assign store_we_d = commit && wr_q && !range_err;

  // Response word: written data for writes, stored word for reads, zero on error.
  always_comb begin
    resp_data_d = store_rdata;
    if (range_err) begin
      resp_data_d = '0;
    end else if (wr_q) begin
      resp_data_d = wdata_q;
    end
  end

  mem_responder_store #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .we_i    (store_we_d),
    .waddr_i (slot),
    .wdata_i (wdata_q),
    .raddr_i (slot),
    .rdata_o (store_rdata)
  );

  // Transaction FSM with latency counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (mem_rd || mem_wr) begin
            addr_q  <= mem_addr;
            wr_q    <= mem_wr;
            wdata_q <= mem_wr_data;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rdata_q <= resp_data_d;
            ready_q <= 1'b1;
            err_q   <= range_err;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_busy  = (state_q == WAIT);

endmodule
